// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer_if
// Purpose  : Instruction-memory fetch handshake between the PC sequencer
//            (master) and instruction memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] instr;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  instr
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output instr
    );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Multi-cycle PC sequencer: fetch / wait / execute / PC update
//            with branch resolution, fetch timeout and alignment checking.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [63:0] RESET_PC      = 64'd0,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        start,
    input  wire logic        halt,
    pc_sequencer_if.master   imem,
    output logic      [31:0] instr_out,
    output logic             instr_valid,
    input  wire logic        exec_done,
    input  wire logic        branch,
    input  wire logic        zero,
    input  wire logic [63:0] imm,
    output logic      [63:0] pc,
    output logic             busy,
    output logic      [1:0]  err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_EXEC   = 3'd3,
        S_UPDATE = 3'd4,
        S_HALTED = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam logic [7:0] c_timeout     = 8'(FETCH_TIMEOUT);
    localparam logic [1:0] c_err_none    = 2'b00;
    localparam logic [1:0] c_err_timeout = 2'b01;
    localparam logic [1:0] c_err_align   = 2'b10;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] target_q, target_d;
    logic        take_q, take_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [1:0]  err_q, err_d;

    logic [7:0]  wait_cnt_inc;
    logic [63:0] next_pc;

    assign wait_cnt_inc = wait_cnt_q + 8'd1;
    assign next_pc      = take_q ? target_q : pc_q + 64'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            target_q   <= '0;
            take_q     <= 1'b0;
            instr_q    <= '0;
            wait_cnt_q <= '0;
            err_q      <= c_err_none;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
            take_q     <= take_d;
            instr_q    <= instr_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        take_d     = take_q;
        instr_d    = instr_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // Ready takes priority over a timeout landing in the same cycle.
                if (imem.imem_ready) begin
                    instr_d = imem.instr;
                    state_d = S_EXEC;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                    if (wait_cnt_inc == c_timeout) begin
                        err_d   = c_err_timeout;
                        state_d = S_ERROR;
                    end
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    take_d   = branch & zero;
                    target_d = pc_q + {imm[62:0], 1'b0};
                    state_d  = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (next_pc[1:0] != 2'b00) begin
                    err_d   = c_err_align;
                    state_d = S_ERROR;
                end else begin
                    pc_d    = next_pc;
                    state_d = halt ? S_HALTED : S_FETCH;
                end
            end
            default: begin
                // HALTED and ERROR are terminal until reset.
                state_d = state_q;
            end
        endcase
    end

    assign imem.imem_req  = (state_q == S_FETCH);
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign instr_out      = instr_q;
    assign instr_valid    = (state_q == S_EXEC);
    assign busy           = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                            (state_q == S_EXEC)  || (state_q == S_UPDATE);
    assign err            = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer against a PC-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, halt, exec_done, branch, zero, imem_ready;
    logic [63:0] imm;
    logic [31:0] instr;

    logic [31:0] instr_out, w_instr_out;
    logic        instr_valid, w_instr_valid, busy, w_busy;
    logic [63:0] pc, w_pc;
    logic [1:0]  err, w_err;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] model_pc;

    pc_sequencer_if bus ();
    pc_sequencer_if bus_w ();
    assign bus.imem_ready   = imem_ready;
    assign bus.instr        = instr;
    assign bus_w.imem_ready = imem_ready;
    assign bus_w.instr      = instr;

    pc_sequencer #(.RESET_PC(64'd0), .FETCH_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .imem(bus),
        .instr_out(instr_out), .instr_valid(instr_valid), .exec_done(exec_done),
        .branch(branch), .zero(zero), .imm(imm), .pc(pc), .busy(busy), .err(err)
    );

    pc_sequencer #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .FETCH_TIMEOUT(16)) dut_wrap (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .imem(bus_w),
        .instr_out(w_instr_out), .instr_valid(w_instr_valid), .exec_done(exec_done),
        .branch(branch), .zero(zero), .imm(imm), .pc(w_pc), .busy(w_busy), .err(w_err)
    );

    always #5 clk = ~clk;

    task automatic do_reset;
        reset = 1'b0; start = 0; halt = 0; exec_done = 0; branch = 0; zero = 0;
        imem_ready = 0; imm = '0; instr = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pc !== 64'd0 || instr_out !== 32'd0 || instr_valid !== 1'b0 || busy !== 1'b0 ||
            err !== 2'b00 || bus.imem_req !== 1'b0 || bus.imem_addr !== 64'd0)
            begin errors++; $display("FAIL reset_state: pc=%h instr_out=%h valid=%b busy=%b err=%b req=%b expected pc=0 all zero",
                                     pc, instr_out, instr_valid, busy, err, bus.imem_req); end
        checks++;
        if (w_pc !== 64'hFFFF_FFFF_FFFF_FFFC)
            begin errors++; $display("FAIL reset_pc_param: pc=%h expected fffffffffffffffc", w_pc); end
        reset = 1'b1;
        model_pc = 64'd0;
    endtask

    task automatic start_seq;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs one instruction starting in FETCH; w = WAIT cycles without ready,
    // d = EXEC cycles without exec_done.
    task automatic run_instr(input int w, input int d, input logic br, input logic z,
                             input logic [63:0] im, input logic hlt, input logic [31:0] iw);
        logic [63:0] old_pc, nxt;
        old_pc = model_pc;
        nxt    = (br && z) ? model_pc + (im << 1) : model_pc + 64'd4;

        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== model_pc || busy !== 1'b1)
            begin errors++; $display("FAIL fetch: req=%b addr=%h busy=%b expected req=1 addr=%h busy=1",
                                     bus.imem_req, bus.imem_addr, busy, model_pc); end
        imem_ready = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i <= w; i++) begin
            checks++;
            if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || busy !== 1'b1 || pc !== old_pc)
                begin errors++; $display("FAIL wait_state %0d: req=%b valid=%b busy=%b pc=%h expected 0 0 1 %h",
                                         i, bus.imem_req, instr_valid, busy, pc, old_pc); end
            start     = 1'($urandom_range(0, 1));
            halt      = 1'($urandom_range(0, 1));
            exec_done = 1'($urandom_range(0, 1));
            if (i < w) begin
                imem_ready = 1'b0;
                instr      = $urandom;
            end else begin
                imem_ready = 1'b1;
                instr      = iw;
            end
            @(posedge clk); #1;
        end
        start = 0;
        for (int i = 0; i <= d; i++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== iw || pc !== old_pc || busy !== 1'b1)
                begin errors++; $display("FAIL exec %0d: valid=%b instr_out=%h pc=%h expected 1 %h %h",
                                         i, instr_valid, instr_out, pc, iw, old_pc); end
            imem_ready = 1'($urandom_range(0, 1));
            instr      = $urandom;
            if (i < d) begin
                exec_done = 1'b0;
                branch = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1));
                imm = {$urandom, $urandom};
            end else begin
                exec_done = 1'b1; branch = br; zero = z; imm = im;
            end
            @(posedge clk); #1;
        end
        exec_done = 0;
        branch = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1));
        imm = {$urandom, $urandom};
        halt = hlt;
        checks++;
        if (instr_valid !== 1'b0 || busy !== 1'b1 || pc !== old_pc || bus.imem_req !== 1'b0)
            begin errors++; $display("FAIL update: valid=%b busy=%b pc=%h req=%b expected 0 1 %h 0",
                                     instr_valid, busy, pc, bus.imem_req, old_pc); end
        @(posedge clk); #1;
        halt = 0;
        imem_ready = 0;
        if (nxt[1:0] != 2'b00) begin
            checks++;
            if (err !== 2'b10 || pc !== old_pc || busy !== 1'b0 || bus.imem_req !== 1'b0)
                begin errors++; $display("FAIL misaligned: err=%b pc=%h busy=%b req=%b expected 10 %h 0 0",
                                         err, pc, busy, bus.imem_req, old_pc); end
        end else if (hlt) begin
            checks++;
            if (pc !== nxt || busy !== 1'b0 || bus.imem_req !== 1'b0 || err !== 2'b00)
                begin errors++; $display("FAIL halt_entry: pc=%h busy=%b req=%b err=%b expected %h 0 0 00",
                                         pc, busy, bus.imem_req, err, nxt); end
            model_pc = nxt;
        end else begin
            checks++;
            if (pc !== nxt || bus.imem_addr !== nxt || bus.imem_req !== 1'b1 || err !== 2'b00)
                begin errors++; $display("FAIL pc_update: pc=%h addr=%h req=%b err=%b expected %h %h 1 00",
                                         pc, bus.imem_addr, bus.imem_req, err, nxt, nxt); end
            model_pc = nxt;
        end
    endtask

    task automatic test_reset_start;
        do_reset();
        start_seq();
        run_instr(0, 0, 1'b0, 1'b0, 64'd0, 1'b0, 32'h0000_0013);
        checks++;
        if (w_pc !== 64'd0 || w_instr_out !== 32'h0000_0013)
            begin errors++; $display("FAIL pc_wrap: pc=%h instr_out=%h expected 0 00000013", w_pc, w_instr_out); end
    endtask

    task automatic test_branch;
        do_reset();
        start_seq();
        run_instr(0, 0, 1'b1, 1'b1, 64'h80, 1'b0, $urandom);
        run_instr(1, 1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, $urandom);
        checks++;
        if (pc !== 64'hF0) begin errors++; $display("FAIL taken_branch: pc=%h expected f0", pc); end
        do_reset();
        start_seq();
        run_instr(0, 0, 1'b1, 1'b1, 64'h80, 1'b0, $urandom);
        run_instr(0, 2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, $urandom);
        checks++;
        if (pc !== 64'h104) begin errors++; $display("FAIL not_taken: pc=%h expected 104", pc); end
    endtask

    task automatic test_wait_states;
        do_reset();
        start_seq();
        run_instr(3, 0, 1'b0, 1'b0, 64'd0, 1'b0, $urandom);
        run_instr(15, 0, 1'b0, 1'b0, 64'd0, 1'b0, $urandom);
    endtask

    task automatic test_timeout;
        do_reset();
        start_seq();
        imem_ready = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b1 || err !== 2'b00)
                begin errors++; $display("FAIL timeout_wait %0d: busy=%b err=%b expected 1 00", k, busy, err); end
        end
        @(posedge clk); #1;
        checks++;
        if (err !== 2'b01 || busy !== 1'b0 || pc !== 64'd0)
            begin errors++; $display("FAIL timeout: err=%b busy=%b pc=%h expected 01 0 0", err, busy, pc); end
        start = 1; imem_ready = 1; exec_done = 1;
        repeat (4) @(posedge clk);
        #1;
        start = 0; imem_ready = 0; exec_done = 0;
        checks++;
        if (err !== 2'b01 || bus.imem_req !== 1'b0 || pc !== 64'd0 || instr_valid !== 1'b0)
            begin errors++; $display("FAIL error_sticky: err=%b req=%b pc=%h expected 01 0 0", err, bus.imem_req, pc); end
    endtask

    task automatic test_misaligned;
        do_reset();
        start_seq();
        run_instr(0, 0, 1'b1, 1'b1, 64'h100, 1'b0, $urandom);
        run_instr(0, 0, 1'b1, 1'b1, 64'd1, 1'b0, $urandom);
        for (int k = 0; k < 5; k++) begin
            start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            checks++;
            if (bus.imem_req !== 1'b0 || pc !== 64'h200 || err !== 2'b10)
                begin errors++; $display("FAIL misaligned_hold %0d: req=%b pc=%h err=%b expected 0 200 10",
                                         k, bus.imem_req, pc, err); end
        end
        start = 0;
    endtask

    task automatic test_halt;
        do_reset();
        start_seq();
        for (int k = 0; k < 4; k++)
            run_instr($urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b1, {$urandom, $urandom}, 1'b0, $urandom);
        checks++;
        if (pc !== 64'h10) begin errors++; $display("FAIL pre_halt: pc=%h expected 10", pc); end
        run_instr(0, 0, 1'b0, 1'b0, 64'd0, 1'b1, $urandom);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pc !== 64'h14 || busy !== 1'b0 || bus.imem_req !== 1'b0 || err !== 2'b00)
            begin errors++; $display("FAIL halted_start: pc=%h busy=%b req=%b err=%b expected 14 0 0 00",
                                     pc, busy, bus.imem_req, err); end
    endtask

    task automatic test_random;
        logic [63:0] r_imm;
        do_reset();
        start_seq();
        for (int k = 0; k < 30; k++) begin
            r_imm = {$urandom, $urandom} & ~64'd1;
            run_instr($urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), r_imm, 1'(k == 29), $urandom);
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        start_seq();
        run_instr(0, 0, 1'b0, 1'b0, 64'd0, 1'b0, 32'hDEAD_BEEF);
        imem_ready = 1; instr = 32'h1234_5678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        imem_ready = 0;
        checks++;
        if (instr_valid !== 1'b1 || instr_out !== 32'h1234_5678)
            begin errors++; $display("FAIL pre_reset_exec: valid=%b instr_out=%h expected 1 12345678", instr_valid, instr_out); end
        exec_done = 1; branch = 1; zero = 1; imm = 64'h40;
        #2;
        reset = 0;
        #1;
        checks++;
        if (pc !== 64'd0 || instr_out !== 32'd0 || instr_valid !== 1'b0 || busy !== 1'b0 ||
            err !== 2'b00 || bus.imem_req !== 1'b0 || w_pc !== 64'hFFFF_FFFF_FFFF_FFFC)
            begin errors++; $display("FAIL async_reset: pc=%h instr_out=%h valid=%b busy=%b err=%b req=%b expected all reset values",
                                     pc, instr_out, instr_valid, busy, err, bus.imem_req); end
        @(posedge clk); #1;
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        exec_done = 0;
        checks++;
        if (pc !== 64'd0 || busy !== 1'b0 || instr_valid !== 1'b0)
            begin errors++; $display("FAIL post_reset_idle: pc=%h busy=%b valid=%b expected 0 0 0", pc, busy, instr_valid); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset_start();
        test_branch();
        test_wait_states();
        test_timeout();
        test_misaligned();
        test_halt();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle program-counter sequencer for the non-pipelined RISC-V core. It owns the PC register and steps the core through fetch, execute and PC update. Fetch uses a request/ready handshake with instruction memory. The PC update applies the branch decision (`branch & zero`) with target = PC + (imm << 1), or PC + 4 otherwise. It sits between instruction memory, the decoder/ALU datapath and the branch-target adder.

## Interface
- `RESET_PC`, 64'd0: PC value after reset.
- `FETCH_TIMEOUT`, 16: maximum WAIT cycles without `imem_ready` before an error; range 1..255.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  leave IDLE and begin fetching; ignored in all other states.
- `halt`  in  1  stop after the current instruction; sampled only in UPDATE.
- `imem_req`  out  1  fetch request, high only in FETCH.
- `imem_addr`  out  64  fetch address, always equal to `pc`.
- `imem_ready`  in  1  instruction valid on `instr`; honoured only in WAIT.
- `instr`  in  32  instruction word from memory.
- `instr_out`  out  32  registered instruction, held from WAIT exit until the next capture.
- `instr_valid`  out  1  high for the whole of EXEC.
- `exec_done`  in  1  datapath has finished the instruction; honoured only in EXEC.
- `branch`, `zero`  in  1 each  branch control and ALU zero flag, sampled with `exec_done`.
- `imm`  in  64  sign-extended immediate, not yet shifted, sampled with `exec_done`.
- `pc`  out  64  current program counter.
- `busy`  out  1  high in FETCH, WAIT, EXEC and UPDATE.
- `err`  out  2  00 none, 01 fetch timeout, 10 misaligned target; sticky until reset.

## Operation
- States: IDLE, FETCH, WAIT, EXEC, UPDATE, HALTED, ERROR.
- Reset (async, `reset`=0) puts every output in a defined state:
  - state = IDLE, `pc` = RESET_PC, `instr_out` = 0.
  - `imem_req`, `instr_valid`, `busy` = 0; `err` = 00.
  - Wait counter = 0, latched take flag = 0, latched target = 0.
  - Reset mid-operation abandons the instruction in flight with no PC update.
- IDLE: when `start`=1, go to FETCH.
- FETCH (1 cycle): `imem_req`=1; clear the wait counter; go to WAIT.
- WAIT:
  - If `imem_ready`=1: `instr_out` <= `instr`; go to EXEC.
  - Otherwise increment the wait counter. When it reaches FETCH_TIMEOUT, go to ERROR with `err`=01.
  - `imem_ready` wins if it arrives in the same cycle the counter would hit the limit.
- EXEC: `instr_valid`=1. When `exec_done`=1:
  - Latch take = `branch & zero`.
  - Latch target = `pc` + (`imm` << 1).
  - Go to UPDATE.
- UPDATE (1 cycle): next = take ? target : `pc` + 4.
  - If next[1:0] != 00: go to ERROR with `err`=10; `pc` is not updated.
  - Otherwise `pc` <= next, then go to HALTED if `halt`=1, else go to FETCH.
- HALTED and ERROR are terminal; only reset leaves them. `pc` holds its value.
- Arithmetic is 64-bit modulo 2^64 and wraps silently.
  - `imm` << 1 discards `imm[63]`.
  - PC + 4 from 64'hFFFF_FFFF_FFFF_FFFC gives 0.
- Inputs arriving outside their honouring state (`start`, `imem_ready`, `exec_done`) are ignored and not remembered.

## Timing
- Minimum is 4 cycles per instruction: FETCH, WAIT (`imem_ready` on the first WAIT cycle), EXEC (`exec_done` on the first cycle), UPDATE.
- `pc` / `imem_addr` change only on the clock edge leaving UPDATE.
- `instr_out` is valid from the first EXEC cycle.
- Each wait-state adds one cycle, up to FETCH_TIMEOUT of them.
- `start` at edge N puts the FSM in FETCH in cycle N+1.
- All outputs are registered or decoded from the state register; there is no combinational path from any input to any output.

## Test plan
- Reset then start: after `reset` 0→1 and a `start` pulse, `imem_req`=1 for exactly one cycle with `imem_addr`=0. Ready on the first WAIT cycle with `instr`=32'h00000013. Then `instr_out`=32'h00000013, `instr_valid`=1, and `pc`=4 four cycles after FETCH.
- Taken branch: `pc`=0x100, `branch`=1, `zero`=1, `imm`=-8 (64'hFFFF_FFFF_FFFF_FFF8) with `exec_done` → `pc`=0xF0. Same inputs with `zero`=0 → `pc`=0x104.
- Wait states and timeout:
  - `imem_ready` delayed 3 cycles → EXEC entered after exactly 3 extra cycles.
  - `imem_ready` never asserted with FETCH_TIMEOUT=16 → `err`=01 after 16 WAIT cycles; `busy`=0; `pc` unchanged.
- Misaligned target: `pc`=0x200, taken branch with `imm`=1 → target 0x202 → `err`=10; `pc` stays 0x200; no further `imem_req`.
- Halt and wrap:
  - `halt`=1 during UPDATE at `pc`=0x10 → `pc`=0x14, HALTED, `busy`=0; `start` is then ignored.
  - With RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, one instruction completes → `pc`=0.
- Async reset mid-EXEC: drive `reset`=0 between clock edges → all outputs return to their reset values immediately, and a pending `exec_done` causes no update.
